// File: rtl/ones_pkg.sv
// Shared constants and FSM state type for the serial ones framer.
package ones_pkg;

  localparam int FRAME_W = 7;
  localparam int COUNT_W = 3;
  localparam int IDX_W   = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_W - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/popcount7.sv
// Combinational ones counter for one 7-bit frame.
module popcount7
  import ones_pkg::*;
(
  input  logic [FRAME_W-1:0] bits,
  output logic [COUNT_W-1:0] ones
);

  // NOTE: every variable written in always_comb gets a default first,
  // otherwise synthesis infers a latch.
  always_comb begin
    ones = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      ones = ones + COUNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/serial_ones_framer.sv
// Assembles 7 serial bits LSB-first into a frame, counts its ones and keeps a
// saturating running total. Define ONES_PARITY_EN to add the parity output.
module serial_ones_framer
  import ones_pkg::*;
#(
  parameter int TOTAL_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  input  logic               out_ready,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame,
  output logic [COUNT_W-1:0] count,
  output logic [TOTAL_W-1:0] total,
`ifdef ONES_PARITY_EN
  output logic               parity,
`endif
  input  logic               total_clr
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] frame_d;
  logic [COUNT_W-1:0] count_d;
  logic               handshake;
  logic [TOTAL_W:0]   total_sum;

  assign bit_ready   = (state_q == COLLECT);
  assign frame_valid = (state_q == HOLD);
  assign handshake   = frame_valid & out_ready;
  assign total_sum   = {1'b0, total} + (TOTAL_W + 1)'(count);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame;
    unique case (state_q)
      COLLECT: begin
        if (bit_valid) begin
          // The first bit of a frame starts from a clean slate.
          if (idx_q == '0) frame_d = '0;
          frame_d[idx_q] = bit_in;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  popcount7 u_popcount (
    .bits (frame_d),
    .ones (count_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      frame   <= '0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame   <= frame_d;
      count   <= count_d;
    end
  end

  // Clear wins over a same-cycle handshake; the frame's count is dropped.
  always_ff @(posedge clk) begin
    if (rst || total_clr) begin
      total <= '0;
    end else if (handshake) begin
      total <= total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
    end
  end

`ifdef ONES_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity <= 1'b0;
    else     parity <= count_d[0];
  end
`endif

endmodule

// File: tb/tb_serial_ones_framer.sv
// Scoreboard bench for serial_ones_framer: expected frames are queued as bits
// are driven and compared when the DUT presents them.
module tb_serial_ones_framer;
  import ones_pkg::*;

  localparam int TOTAL_W   = 10;
  localparam int MAX_TOTAL = (1 << TOTAL_W) - 1;

  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    logic [COUNT_W-1:0] count;
    logic               parity;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst, bit_in, bit_valid, bit_ready, out_ready;
  logic               frame_valid, total_clr;
  logic [FRAME_W-1:0] frame;
  logic [COUNT_W-1:0] count;
  logic [TOTAL_W-1:0] total;
`ifdef ONES_PARITY_EN
  logic               parity;
`endif

  exp_t               sb[$];
  int                 checks = 0;
  int                 errors = 0;
  int                 m_idx  = 0;
  logic [FRAME_W-1:0] m_frame = '0;
  int                 m_total = 0;

  always #5 clk = ~clk;

  serial_ones_framer #(.TOTAL_W(TOTAL_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .out_ready   (out_ready),
    .frame_valid (frame_valid),
    .frame       (frame),
    .count       (count),
    .total       (total),
`ifdef ONES_PARITY_EN
    .parity      (parity),
`endif
    .total_clr   (total_clr)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Drives one accepted bit after an optional idle gap; inputs change and
  // outputs are sampled on the falling edge.
  task automatic send_bit(input logic b, input int gap);
    exp_t e;
    repeat (gap) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
      @(negedge clk);
    end
    check("bit_ready_collect", 32'(bit_ready), 32'd1);
    bit_valid = 1'b1;
    bit_in    = b;
    @(negedge clk);
    bit_valid = 1'b0;
    m_frame[m_idx] = b;
    m_idx++;
    if (m_idx == FRAME_W) begin
      e.frame  = m_frame;
      e.count  = COUNT_W'($countones(m_frame));
      e.parity = e.count[0];
      sb.push_back(e);
      m_idx   = 0;
      m_frame = '0;
      check("fv_latency", 32'(frame_valid), 32'd1);
    end else begin
      check("fv_low_partial", 32'(frame_valid), 32'd0);
    end
  endtask

  task automatic send_frame(input logic [FRAME_W-1:0] f, input int max_gap);
    for (int k = 0; k < FRAME_W; k++) begin
      send_bit(f[k], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    end
  endtask

  // Holds the frame for hold_cycles while offering bits, then handshakes.
  task automatic consume(input int hold_cycles, input logic clr);
    exp_t e;
    int   t = 0;
    while (!frame_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("fv_timeout", 32'(frame_valid), 32'd1);
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    repeat (hold_cycles) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom);
      out_ready = 1'b0;
      @(negedge clk);
      check("bit_ready_hold", 32'(bit_ready), 32'd0);
      check("frame_stable", 32'(frame), 32'(e.frame));
    end
    bit_valid = 1'b0;
    check("frame", 32'(frame), 32'(e.frame));
    check("count", 32'(count), 32'(e.count));
`ifdef ONES_PARITY_EN
    check("parity", 32'(parity), 32'(e.parity));
`endif
    out_ready = 1'b1;
    total_clr = clr;
    @(negedge clk);
    out_ready = 1'b0;
    total_clr = 1'b0;
    if (clr) m_total = 0;
    else     m_total = (m_total + int'(e.count) > MAX_TOTAL) ? MAX_TOTAL : m_total + int'(e.count);
    check("fv_after_hs", 32'(frame_valid), 32'd0);
    check("bit_ready_after_hs", 32'(bit_ready), 32'd1);
    check("total", 32'(total), 32'(m_total));
  endtask

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0; total_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_total", 32'(total), 32'd0);
    check("rst_bit_ready", 32'(bit_ready), 32'd1);
`ifdef ONES_PARITY_EN
    check("rst_parity", 32'(parity), 32'd0);
`endif
    rst = 1'b0;

    // Bits 1,0,1,1,0,0,1 -> 7'b1001101, count 4, then a 5-cycle stall.
    send_frame(7'b1001101, 0);
    consume(5, 1'b0);

    // Saturation of the running total.
    repeat (147) begin
      send_frame(7'h7f, 0);
      consume(0, 1'b0);
    end
    check("total_saturated", 32'(total), 32'(MAX_TOTAL));

    // Clear on the same cycle as a count-7 handshake.
    send_frame(7'h7f, 0);
    consume(1, 1'b1);

    // Clear mid-frame leaves the partial frame intact.
    send_frame(7'h7f, 0);
    consume(0, 1'b0);
    for (int k = 0; k < 3; k++) send_bit(1'b1, 0);
    total_clr = 1'b1;
    @(negedge clk);
    total_clr = 1'b0;
    m_total = 0;
    check("total_clr_alone", 32'(total), 32'd0);
    for (int k = 3; k < FRAME_W; k++) send_bit(k[0], 0);
    consume(0, 1'b0);

    // Reset after three bits discards the partial frame.
    total_clr = 1'b1;
    @(negedge clk);
    total_clr = 1'b0;
    m_total = 0;
    for (int k = 0; k < 3; k++) send_bit(1'b1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_idx = 0;
    m_frame = '0;
    check("rst_mid_fv", 32'(frame_valid), 32'd0);
    check("rst_mid_total", 32'(total), 32'd0);
    check("rst_mid_frame", 32'(frame), 32'd0);
    send_frame(7'b0010110, 0);
    consume(0, 1'b0);

    // Random gaps in bit_valid.
    send_frame(7'b0000000, 3);
    consume(2, 1'b0);
    send_frame(7'b1111111, 3);
    consume(0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
